// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: bundle geometry, length encoding, line-offset bit
// positions and the sequencer state encoding.
package fetch_unit_pkg;

  localparam int instructionsPerBundle = 4;
  localparam int wordBits              = 32;
  localparam int bundleBits            = instructionsPerBundle * wordBits;
  localparam int lineBytesLog2         = 4;
  localparam int lineBytes             = 1 << lineBytesLog2;

  // Word offset within a 16-byte line lives in address bits [3:2]
  localparam int offsetLsb = 2;
  localparam int offsetMsb = 3;

  // bundleLen encodes (valid instruction count - 1)
  localparam logic [1:0] lenFull = 2'b11;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetchState_t;

  function automatic logic [2:0] lenToCount(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch sequencer and its environment (core control,
// instruction cache and fetch queue). master = fetch unit side.
interface fetch_unit_if #(
  parameter int addressWidth            = 64,
  parameter int maxBundleSize           = 128,
  parameter int PidSize                 = 32,
  parameter int TidSize                 = 64,
  parameter int instructionCounterWidth = 64
);

  logic [PidSize-1:0]                 pid_i;
  logic [TidSize-1:0]                 tid_i;
  logic                               redirect_i;
  logic [addressWidth-1:0]            redirectAddress_i;
  logic                               queueFull_i;

  logic                               cacheReq_o;
  logic [addressWidth-1:0]            cacheAddress_o;
  logic                               cacheAck_i;
  logic [maxBundleSize-1:0]           cacheData_i;

  logic                               bundleWrite_o;
  logic [addressWidth-1:0]            bundleAddress_o;
  logic [1:0]                         bundleLen_o;
  logic [PidSize-1:0]                 bundlePid_o;
  logic [TidSize-1:0]                 bundleTid_o;
  logic [instructionCounterWidth-1:0] bundleStartMajId_o;
  logic [maxBundleSize-1:0]           bundle_o;

  modport master (
    input  pid_i, tid_i, redirect_i, redirectAddress_i, queueFull_i,
    input  cacheAck_i, cacheData_i,
    output cacheReq_o, cacheAddress_o,
    output bundleWrite_o, bundleAddress_o, bundleLen_o, bundlePid_o,
    output bundleTid_o, bundleStartMajId_o, bundle_o
  );

  modport slave (
    output pid_i, tid_i, redirect_i, redirectAddress_i, queueFull_i,
    output cacheAck_i, cacheData_i,
    input  cacheReq_o, cacheAddress_o,
    input  bundleWrite_o, bundleAddress_o, bundleLen_o, bundlePid_o,
    input  bundleTid_o, bundleStartMajId_o, bundle_o
  );

endinterface

// File: rtl/fetch_align.sv
// Drops the words ahead of the fetch offset, left-justifies the rest into
// slot 0 and zero-fills the tail; also produces the bundle length code.
module fetch_align
  import fetch_unit_pkg::*;
#(
  parameter int instructionWidth = 32,
  parameter int maxBundleSize    = 128
) (
  input  logic [maxBundleSize-1:0] line,
  input  logic [1:0]               offset,
  output logic [maxBundleSize-1:0] bundle,
  output logic [1:0]               len
);

  // Word 0 sits in the most significant bits, so a left shift moves
  // word <offset> into slot 0 and shifts zeros into the vacated slots.
  always_comb begin
    bundle = line << (int'(offset) * instructionWidth);
    len    = lenFull - offset;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer: owns the PC and major-ID counter, issues one aligned line
// request at a time and turns each returned line into a tagged bundle.
//
//   state | meaning
//   REQ   | cache request asserted for the line containing PC
//   HOLD  | line captured in the bundle registers, waiting for queue space
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                      addressWidth            = 64,
  parameter int                      instructionWidth        = 32,
  parameter int                      maxBundleSize           = 128,
  parameter int                      PidSize                 = 32,
  parameter int                      TidSize                 = 64,
  parameter int                      instructionCounterWidth = 64,
  parameter logic [addressWidth-1:0] resetVector             = '0
) (
  input logic          clock_i,
  input logic          reset_i,
  fetch_unit_if.master bus
);

  fetchState_t                        state, stateNext;
  logic [addressWidth-1:0]            pc, pcNext;
  logic [addressWidth-1:0]            alignedPc, nextLinePc;
  logic [instructionCounterWidth-1:0] majId, majIdNext;
  logic                               writeNext;
  logic                               captureEn;

  logic [maxBundleSize-1:0]           alignBundle;
  logic [1:0]                         alignLen;

  logic                               bundleWrite;
  logic [addressWidth-1:0]            bundleAddress;
  logic [1:0]                         bundleLen;
  logic [PidSize-1:0]                 bundlePid;
  logic [TidSize-1:0]                 bundleTid;
  logic [instructionCounterWidth-1:0] bundleStartMajId;
  logic [maxBundleSize-1:0]           bundleData;

  assign alignedPc  = {pc[addressWidth-1:lineBytesLog2], {lineBytesLog2{1'b0}}};
  assign nextLinePc = alignedPc + addressWidth'(lineBytes);

  fetch_align #(
    .instructionWidth (instructionWidth),
    .maxBundleSize    (maxBundleSize)
  ) u_align (
    .line   (bus.cacheData_i),
    .offset (pc[offsetMsb:offsetLsb]),
    .bundle (alignBundle),
    .len    (alignLen)
  );

  // PC is untouched while in HOLD, so alignLen still describes the held line
  // and serves the major-ID advance in both states.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    majIdNext = majId;
    writeNext = 1'b0;
    captureEn = 1'b0;

    if (bus.redirect_i) begin
      pcNext    = bus.redirectAddress_i;
      stateNext = REQ;
    end else begin
      case (state)
        REQ: begin
          if (bus.cacheAck_i) begin
            captureEn = 1'b1;
            if (bus.queueFull_i) begin
              stateNext = HOLD;
            end else begin
              writeNext = 1'b1;
              pcNext    = nextLinePc;
              majIdNext = majId + instructionCounterWidth'(lenToCount(alignLen));
            end
          end
        end
        HOLD: begin
          if (!bus.queueFull_i) begin
            writeNext = 1'b1;
            pcNext    = nextLinePc;
            majIdNext = majId + instructionCounterWidth'(lenToCount(alignLen));
            stateNext = REQ;
          end
        end
        default: stateNext = REQ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state            <= REQ;
      pc               <= resetVector;
      majId            <= '0;
      bundleWrite      <= 1'b0;
      bundleAddress    <= '0;
      bundleLen        <= '0;
      bundlePid        <= '0;
      bundleTid        <= '0;
      bundleStartMajId <= '0;
      bundleData       <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      majId       <= majIdNext;
      bundleWrite <= writeNext;
      // A stalled line parks in the output registers; the write pulse comes later
      if (captureEn) begin
        bundleAddress    <= pc;
        bundleLen        <= alignLen;
        bundlePid        <= bus.pid_i;
        bundleTid        <= bus.tid_i;
        bundleStartMajId <= majId;
        bundleData       <= alignBundle;
      end
    end
  end

  assign bus.cacheReq_o         = (state == REQ);
  assign bus.cacheAddress_o     = alignedPc;
  assign bus.bundleWrite_o      = bundleWrite;
  assign bus.bundleAddress_o    = bundleAddress;
  assign bus.bundleLen_o        = bundleLen;
  assign bus.bundlePid_o        = bundlePid;
  assign bus.bundleTid_o        = bundleTid;
  assign bus.bundleStartMajId_o = bundleStartMajId;
  assign bus.bundle_o           = bundleData;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected bundles into a
// queue, a negedge monitor pops and compares every bundle write.
module tb_fetch_unit;

  logic clock;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]  addr;
    logic [1:0]   len;
    logic [31:0]  pid;
    logic [63:0]  tid;
    logic [63:0]  maj;
    logic [127:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks    = 0;
  int   failures  = 0;
  bit   monitorOn = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expectBundle(input logic [63:0] addr, input logic [1:0] len,
                              input logic [31:0] pid, input logic [63:0] tid,
                              input logic [63:0] maj, input logic [127:0] data);
    exp_t e;
    e.addr = addr; e.len = len; e.pid = pid; e.tid = tid; e.maj = maj; e.data = data;
    expQ.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic ackLine(input logic [127:0] data);
    bus.cacheAck_i  = 1'b1;
    bus.cacheData_i = data;
    tick();
    bus.cacheAck_i  = 1'b0;
    bus.cacheData_i = '0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (monitorOn && bus.bundleWrite_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%h actual=write expected=none", bus.bundleAddress_o);
      end else begin
        e = expQ.pop_front();
        chk("bundle_addr", 128'(bus.bundleAddress_o), 128'(e.addr));
        chk("bundle_len", 128'(bus.bundleLen_o), 128'(e.len));
        chk("bundle_pid", 128'(bus.bundlePid_o), 128'(e.pid));
        chk("bundle_tid", 128'(bus.bundleTid_o), 128'(e.tid));
        chk("bundle_majid", 128'(bus.bundleStartMajId_o), 128'(e.maj));
        chk("bundle_data", bus.bundle_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset                 = 1'b0;
    bus.pid_i             = '0;
    bus.tid_i             = '0;
    bus.redirect_i        = 1'b0;
    bus.redirectAddress_i = '0;
    bus.queueFull_i       = 1'b0;
    bus.cacheAck_i        = 1'b0;
    bus.cacheData_i       = '0;

    // Reset
    tick();
    reset = 1'b1;
    chk("reset_req", 128'(bus.cacheReq_o), 128'(1));
    chk("reset_addr", 128'(bus.cacheAddress_o), 128'(0));
    chk("reset_write", 128'(bus.bundleWrite_o), 128'(0));
    chk("reset_bundle", bus.bundle_o, 128'(0));
    monitorOn = 1'b1;

    // Aligned fetches
    bus.pid_i = 32'd5;
    bus.tid_i = 64'd7;
    expectBundle(64'h0, 2'b11, 32'd5, 64'd7, 64'd0,
                 {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD});
    ackLine({32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD});
    chk("aligned_write", 128'(bus.bundleWrite_o), 128'(1));
    chk("aligned_next_addr", 128'(bus.cacheAddress_o), 128'(64'h10));
    bus.pid_i = 32'd6;
    expectBundle(64'h10, 2'b11, 32'd6, 64'd7, 64'd4,
                 {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404});
    ackLine({32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404});
    chk("aligned2_next_addr", 128'(bus.cacheAddress_o), 128'(64'h20));

    // Stall on queue full; tags are those at the ack edge
    bus.queueFull_i = 1'b1;
    bus.pid_i       = 32'd9;
    bus.tid_i       = 64'h10;
    ackLine({32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888});
    bus.pid_i = 32'hFF;
    bus.tid_i = 64'hFF;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 128'(bus.cacheReq_o), 128'(0));
      chk("stall_write", 128'(bus.bundleWrite_o), 128'(0));
      tick();
    end
    expectBundle(64'h20, 2'b11, 32'd9, 64'h10, 64'd8,
                 {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888});
    bus.queueFull_i = 1'b0;
    tick();
    chk("drain_write", 128'(bus.bundleWrite_o), 128'(1));
    chk("drain_next_addr", 128'(bus.cacheAddress_o), 128'(64'h30));
    chk("drain_req", 128'(bus.cacheReq_o), 128'(1));
    tick();
    chk("drain_single_pulse", 128'(bus.bundleWrite_o), 128'(0));

    // Unaligned redirect
    bus.pid_i             = 32'd1;
    bus.tid_i             = 64'd2;
    bus.redirect_i        = 1'b1;
    bus.redirectAddress_i = 64'h108;
    tick();
    bus.redirect_i = 1'b0;
    chk("redir_addr", 128'(bus.cacheAddress_o), 128'(64'h100));
    expectBundle(64'h108, 2'b01, 32'd1, 64'd2, 64'd12,
                 {32'h33333333, 32'h44444444, 32'h0, 32'h0});
    ackLine({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    chk("redir_next_addr", 128'(bus.cacheAddress_o), 128'(64'h110));

    // Redirect kills same-cycle ack
    bus.redirect_i        = 1'b1;
    bus.redirectAddress_i = 64'h20C;
    ackLine({32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF});
    bus.redirect_i = 1'b0;
    chk("kill_write", 128'(bus.bundleWrite_o), 128'(0));
    chk("kill_addr", 128'(bus.cacheAddress_o), 128'(64'h200));
    expectBundle(64'h20C, 2'b00, 32'd1, 64'd2, 64'd14,
                 {32'h90000004, 32'h0, 32'h0, 32'h0});
    ackLine({32'h90000001, 32'h90000002, 32'h90000003, 32'h90000004});
    chk("last_word_next_addr", 128'(bus.cacheAddress_o), 128'(64'h210));

    // Redirect during HOLD discards the held line
    bus.queueFull_i = 1'b1;
    ackLine({32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE});
    chk("hold_req", 128'(bus.cacheReq_o), 128'(0));
    bus.redirect_i        = 1'b1;
    bus.redirectAddress_i = 64'h400;
    tick();
    bus.redirect_i  = 1'b0;
    bus.queueFull_i = 1'b0;
    chk("hold_redir_req", 128'(bus.cacheReq_o), 128'(1));
    chk("hold_redir_addr", 128'(bus.cacheAddress_o), 128'(64'h400));
    tick();
    tick();
    chk("hold_discard_write", 128'(bus.bundleWrite_o), 128'(0));
    expectBundle(64'h400, 2'b11, 32'd1, 64'd2, 64'd15,
                 {32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4});
    ackLine({32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4});

    // PC wraps at the top of the address space
    bus.redirect_i        = 1'b1;
    bus.redirectAddress_i = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    bus.redirect_i = 1'b0;
    expectBundle(64'hFFFF_FFFF_FFFF_FFF8, 2'b01, 32'd1, 64'd2, 64'd19,
                 {32'hB3B3B3B3, 32'hB4B4B4B4, 32'h0, 32'h0});
    ackLine({32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3, 32'hB4B4B4B4});
    chk("wrap_addr", 128'(bus.cacheAddress_o), 128'(0));

    // Reset overrides redirect and ack, clears majId
    reset                 = 1'b0;
    bus.redirect_i        = 1'b1;
    bus.redirectAddress_i = 64'h800;
    ackLine({32'hCAFECAFE, 32'hCAFECAFE, 32'hCAFECAFE, 32'hCAFECAFE});
    reset          = 1'b1;
    bus.redirect_i = 1'b0;
    chk("rst2_write", 128'(bus.bundleWrite_o), 128'(0));
    chk("rst2_addr", 128'(bus.cacheAddress_o), 128'(0));
    chk("rst2_len", 128'(bus.bundleLen_o), 128'(0));
    expectBundle(64'h0, 2'b11, 32'd1, 64'd2, 64'd0,
                 {32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 32'hC4C4C4C4});
    ackLine({32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 32'hC4C4C4C4});

    tick();
    tick();
    chk("queue_drained", 128'(expQ.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
